// File: rtl/pipe_hazard_ctrl.sv
// Hazard and memory-wait sequencer for a 5-stage RV32I pipeline: stage enables, flushes and dmem handshake.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined; otherwise they read as zero.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_valid,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             dmem_req,
    output logic             mem_err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] tmo_cnt;
    logic [7:0] tmo_next;
    logic [8:0] tmo_inc;
    logic       err_next;
    logic       rs1_used;
    logic       rs2_used;
    logic       load_use;
    logic       mem_access;
    logic       mem_wait;
    logic       branch;

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (id_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            7'b0000011, 7'b0010011: rs1_used = 1'b1;
            default: ;
        endcase
    end

    assign load_use   = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
                        ((rs1_used & (ex_rd == id_rs1)) | (rs2_used & (ex_rd == id_rs2)));
    assign mem_access = mem_valid & (mem_memread | mem_memwrite);
    assign mem_wait   = mem_access & ~dmem_ready;
    assign branch     = ex_branch_taken & ex_valid;
    assign tmo_inc    = {1'b0, tmo_cnt} + 9'd1;

    // Outputs are decoded from the current state and this cycle's inputs; reset forces bubbles.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        dmem_req   = 1'b0;
        state_next = state;
        tmo_next   = tmo_cnt;
        err_next   = mem_err;
        if (reset) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state)
                RUN, LSTALL: begin
                    dmem_req = mem_access;
                    if (mem_wait) begin
                        state_next = MWAIT;
                        tmo_next   = tmo_inc[7:0];
                    end else if (branch) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        state_next = RUN;
                    end else if (load_use && state == RUN) begin
                        {idex_en, exmem_en, memwb_en} = 3'b111;
                        idex_flush = 1'b1;
                        state_next = LSTALL;
                    end else begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                        state_next = RUN;
                    end
                end
                MWAIT: begin
                    dmem_req = mem_access;
                    if (dmem_ready) begin
                        // A branch held in EX during the wait resolves on the release cycle.
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                        ifid_flush = branch;
                        idex_flush = branch;
                        tmo_next   = 8'd0;
                        state_next = RUN;
                    end else begin
                        tmo_next = tmo_inc[7:0];
                        if (tmo_inc >= 9'(MEM_TIMEOUT)) begin
                            state_next = HALT;
                            err_next   = 1'b1;
                        end
                    end
                end
                default: begin
                    err_next = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            tmo_cnt <= 8'd0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_next;
            tmo_cnt <= tmo_next;
            mem_err <= err_next;
        end
    end

    assign state_o = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // A branch flush is the only case with the PC advancing while IF/ID is flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (pc_en && ifid_flush && flush_q != '1)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch flush, memory wait, timeout/HALT and reset abort.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             ex_valid;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             mem_valid;
    logic             mem_memread;
    logic             mem_memwrite;
    logic             dmem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             dmem_req;
    logic             mem_err;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .dmem_req(dmem_req), .mem_err(mem_err), .state_o(state_o),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    wire [4:0] en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    wire [1:0] fl = {ifid_flush, idex_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_opcode = 7'b0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_memread = 0; ex_rd = 0; ex_branch_taken = 0;
        mem_valid = 0; mem_memread = 0; mem_memwrite = 0; dmem_ready = 1;
    endtask

    initial begin
        idle();
        reset = 1;
        #2;
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_fl", 32'(fl), 32'h3);
        chk("rst_req", 32'(dmem_req), 32'h0);
        tick();
        chk("rst_state", 32'(state_o), 32'h0);
        chk("rst_err", 32'(mem_err), 32'h0);
        chk("rst_stall", stall_cycles, 32'h0);
        chk("rst_flush", flush_count, 32'h0);
        reset = 0;
        #1;
        chk("idle_en", 32'(en), 32'h1f);
        chk("idle_fl", 32'(fl), 32'h0);

        // lw x5 in EX, add x6,x5,x1 in ID
        id_valid = 1; id_opcode = 7'b0110011; id_rs1 = 5; id_rs2 = 1;
        ex_valid = 1; ex_memread = 1; ex_rd = 5;
        #1;
        chk("lu_en", 32'(en), 32'h07);
        chk("lu_fl", 32'(fl), 32'h1);
        tick();
        chk("lu_state1", 32'(state_o), 32'h1);
        #1;
        chk("lstall_en", 32'(en), 32'h1f);
        chk("lstall_fl", 32'(fl), 32'h0);
        tick();
        chk("lu_state2", 32'(state_o), 32'h0);

        // load into x0 never stalls
        ex_rd = 0; id_rs1 = 0;
        #1;
        chk("x0_en", 32'(en), 32'h1f);
        tick();
        chk("x0_state", 32'(state_o), 32'h0);

        // I-type ignores rs2
        id_opcode = 7'b0010011; id_rs1 = 1; id_rs2 = 5; ex_rd = 5;
        #1;
        chk("itype_en", 32'(en), 32'h1f);
        tick();

        // branch taken with a coincident load-use
        id_opcode = 7'b0110011; id_rs1 = 5; ex_branch_taken = 1;
        #1;
        chk("br_en", 32'(en), 32'h1f);
        chk("br_fl", 32'(fl), 32'h3);
        tick();
        chk("br_state", 32'(state_o), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
        chk("br_cnt", flush_count, 32'h1);
`else
        chk("br_cnt", flush_count, 32'h0);
`endif

        // store held 3 cycles
        idle();
        mem_valid = 1; mem_memwrite = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_en", 32'(en), 32'h0);
            chk("mw_fl", 32'(fl), 32'h0);
            chk("mw_req", 32'(dmem_req), 32'h1);
            tick();
            chk("mw_state", 32'(state_o), 32'h2);
        end
        dmem_ready = 1;
        #1;
        chk("mw_rel_en", 32'(en), 32'h1f);
        chk("mw_rel_req", 32'(dmem_req), 32'h1);
        tick();
        chk("mw_rel_state", 32'(state_o), 32'h0);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt", stall_cycles, 32'h4);
`else
        chk("stall_cnt", stall_cycles, 32'h0);
`endif

        // timeout with MEM_TIMEOUT=4
        idle();
        mem_valid = 1; mem_memread = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_state", 32'(state_o), 32'h2);
            chk("to_err", 32'(mem_err), 32'h0);
        end
        tick();
        chk("halt_state", 32'(state_o), 32'h3);
        chk("halt_err", 32'(mem_err), 32'h1);
        chk("halt_req", 32'(dmem_req), 32'h0);
        chk("halt_en", 32'(en), 32'h0);
        dmem_ready = 1;
        tick();
        chk("halt_hold", 32'(state_o), 32'h3);
        chk("halt_err2", 32'(mem_err), 32'h1);
        reset = 1;
        #1;
        chk("halt_rst_fl", 32'(fl), 32'h3);
        tick();
        chk("halt_rst_state", 32'(state_o), 32'h0);
        chk("halt_rst_err", 32'(mem_err), 32'h0);
        reset = 0;

        // reset during MWAIT aborts the access
        dmem_ready = 0;
        tick();
        chk("abort_state", 32'(state_o), 32'h2);
        chk("abort_req0", 32'(dmem_req), 32'h1);
        reset = 1;
        #1;
        chk("abort_req", 32'(dmem_req), 32'h0);
        chk("abort_fl", 32'(fl), 32'h3);
        chk("abort_en", 32'(en), 32'h0);
        tick();
        chk("abort_rst_state", 32'(state_o), 32'h0);
        chk("abort_stall", stall_cycles, 32'h0);
        reset = 0;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
